// File: rtl/decode_stage_pkg.sv
// Shared decode constants: instruction fields, opcode/funct values and ALU encodings.
package decode_stage_pkg;

  localparam int unsigned RegisterBus        = 32;
  localparam int unsigned RegisterAddressBus = 5;
  localparam logic [RegisterBus-1:0] ZeroWord = '0;

  localparam logic [5:0] OPC_SPECIAL = 6'h00;
  localparam logic [5:0] OPC_ANDI    = 6'h0C;
  localparam logic [5:0] OPC_ORI     = 6'h0D;
  localparam logic [5:0] OPC_XORI    = 6'h0E;
  localparam logic [5:0] OPC_LUI     = 6'h0F;

  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_XOR = 6'h26;
  localparam logic [5:0] FUNCT_NOR = 6'h27;

  typedef enum logic [7:0] {
    ALU_OP_NOP = 8'h00,
    ALU_OP_AND = 8'h24,
    ALU_OP_OR  = 8'h25,
    ALU_OP_XOR = 8'h26,
    ALU_OP_NOR = 8'h27
  } alu_op_e;

  typedef enum logic [2:0] {
    ALU_SEL_NOP   = 3'b000,
    ALU_SEL_LOGIC = 3'b001
  } alu_sel_e;

endpackage

// File: rtl/decode_stage_logic.sv
// Combinational decoder: instruction word and register-file data in, decoded fields out.
module decode_logic
  import decode_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = RegisterBus,
  parameter int unsigned REG_ADDR_WIDTH = RegisterAddressBus
) (
  input  logic                      valid_i,
  input  logic [DATA_WIDTH-1:0]     instr_i,
  input  logic [DATA_WIDTH-1:0]     read_data1_i,
  input  logic [DATA_WIDTH-1:0]     read_data2_i,
  output logic                      read_enable1_o,
  output logic                      read_enable2_o,
  output logic [REG_ADDR_WIDTH-1:0] read_address1_o,
  output logic [REG_ADDR_WIDTH-1:0] read_address2_o,
  output logic [7:0]                alu_op_o,
  output logic [2:0]                alu_sel_o,
  output logic [DATA_WIDTH-1:0]     operand1_o,
  output logic [DATA_WIDTH-1:0]     operand2_o,
  output logic                      write_enable_o,
  output logic [REG_ADDR_WIDTH-1:0] write_address_o,
  output logic                      illegal_o
);

  logic [5:0]                opcode;
  logic [5:0]                funct;
  logic [REG_ADDR_WIDTH-1:0] rs, rt, rd;
  logic                      re1, re2, wr;
  logic [REG_ADDR_WIDTH-1:0] ra1, ra2, dest;
  logic [DATA_WIDTH-1:0]     imm;
  alu_op_e                   op;
  alu_sel_e                  sel;

  assign opcode = instr_i[31:26];
  assign funct  = instr_i[5:0];
  assign rs     = instr_i[25:21];
  assign rt     = instr_i[20:16];
  assign rd     = instr_i[15:11];

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    re1     = 1'b0;
    re2     = 1'b0;
    ra1     = '0;
    ra2     = '0;
    imm     = '0;
    op      = ALU_OP_NOP;
    sel     = ALU_SEL_NOP;
    dest    = '0;
    wr      = 1'b0;
    illegal_o = 1'b0;
    case (opcode)
      OPC_ANDI, OPC_ORI, OPC_XORI: begin
        re1  = 1'b1;
        ra1  = rs;
        imm  = DATA_WIDTH'(instr_i[15:0]);
        op   = (opcode == OPC_ANDI) ? ALU_OP_AND :
               (opcode == OPC_ORI)  ? ALU_OP_OR  : ALU_OP_XOR;
        sel  = ALU_SEL_LOGIC;
        dest = rt;
        wr   = 1'b1;
      end
      OPC_LUI: begin
        re1  = 1'b1;
        imm  = DATA_WIDTH'({instr_i[15:0], 16'h0000});
        op   = ALU_OP_OR;
        sel  = ALU_SEL_LOGIC;
        dest = rt;
        wr   = 1'b1;
      end
      OPC_SPECIAL: begin
        if (instr_i != ZeroWord) begin
          case (funct)
            FUNCT_AND, FUNCT_OR, FUNCT_XOR, FUNCT_NOR: begin
              re1  = 1'b1;
              re2  = 1'b1;
              ra1  = rs;
              ra2  = rt;
              op   = (funct == FUNCT_AND) ? ALU_OP_AND :
                     (funct == FUNCT_OR)  ? ALU_OP_OR  :
                     (funct == FUNCT_XOR) ? ALU_OP_XOR : ALU_OP_NOR;
              sel  = ALU_SEL_LOGIC;
              dest = rd;
              wr   = 1'b1;
            end
            default: illegal_o = 1'b1;
          endcase
        end
      end
      default: illegal_o = 1'b1;
    endcase
  end

  assign read_enable1_o  = valid_i && re1;
  assign read_enable2_o  = valid_i && re2;
  assign read_address1_o = ra1;
  assign read_address2_o = ra2;
  assign alu_op_o        = op;
  assign alu_sel_o       = sel;
  assign operand1_o      = read_enable1_o ? read_data1_i : '0;
  assign operand2_o      = read_enable2_o ? read_data2_i : imm;
  // Writes to register 0 are architecturally discarded, so suppress them here.
  assign write_enable_o  = wr && (dest != '0);
  assign write_address_o = dest;

endmodule

// File: rtl/decode_stage.sv
// Decode stage: instruction register, register-file read, ID/EX register, valid/ready on both sides.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = RegisterBus,
  parameter int unsigned REG_ADDR_WIDTH = RegisterAddressBus
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_WIDTH-1:0]     in_pc,
  input  logic [DATA_WIDTH-1:0]     in_instruction,
  output logic                      read_enable1,
  output logic                      read_enable2,
  output logic [REG_ADDR_WIDTH-1:0] read_address1,
  output logic [REG_ADDR_WIDTH-1:0] read_address2,
  input  logic [DATA_WIDTH-1:0]     read_data1,
  input  logic [DATA_WIDTH-1:0]     read_data2,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_WIDTH-1:0]     out_pc,
  output logic [7:0]                out_alu_op,
  output logic [2:0]                out_alu_sel,
  output logic [DATA_WIDTH-1:0]     out_operand1,
  output logic [DATA_WIDTH-1:0]     out_operand2,
  output logic                      out_write_enable,
  output logic [REG_ADDR_WIDTH-1:0] out_write_address,
  output logic                      out_illegal
);

  logic                      ir_valid_q, ir_valid_d;
  logic [DATA_WIDTH-1:0]     ir_pc_q, ir_pc_d;
  logic [DATA_WIDTH-1:0]     ir_instr_q, ir_instr_d;

  logic                      out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]     out_pc_q, out_pc_d;
  logic [7:0]                out_alu_op_q, out_alu_op_d;
  logic [2:0]                out_alu_sel_q, out_alu_sel_d;
  logic [DATA_WIDTH-1:0]     out_operand1_q, out_operand1_d;
  logic [DATA_WIDTH-1:0]     out_operand2_q, out_operand2_d;
  logic                      out_we_q, out_we_d;
  logic [REG_ADDR_WIDTH-1:0] out_wa_q, out_wa_d;
  logic                      out_illegal_q, out_illegal_d;

  logic [7:0]                dec_alu_op;
  logic [2:0]                dec_alu_sel;
  logic [DATA_WIDTH-1:0]     dec_operand1, dec_operand2;
  logic                      dec_we, dec_illegal;
  logic [REG_ADDR_WIDTH-1:0] dec_wa;
  logic                      advance;

  decode_logic #(
    .DATA_WIDTH     (DATA_WIDTH),
    .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_decode_logic (
    .valid_i         (ir_valid_q),
    .instr_i         (ir_instr_q),
    .read_data1_i    (read_data1),
    .read_data2_i    (read_data2),
    .read_enable1_o  (read_enable1),
    .read_enable2_o  (read_enable2),
    .read_address1_o (read_address1),
    .read_address2_o (read_address2),
    .alu_op_o        (dec_alu_op),
    .alu_sel_o       (dec_alu_sel),
    .operand1_o      (dec_operand1),
    .operand2_o      (dec_operand2),
    .write_enable_o  (dec_we),
    .write_address_o (dec_wa),
    .illegal_o       (dec_illegal)
  );

  assign advance  = ir_valid_q && (!out_valid_q || out_ready);
  assign in_ready = !flush && (!ir_valid_q || advance);

  always_comb begin
    ir_valid_d     = ir_valid_q;
    ir_pc_d        = ir_pc_q;
    ir_instr_d     = ir_instr_q;
    out_valid_d    = out_valid_q;
    out_pc_d       = out_pc_q;
    out_alu_op_d   = out_alu_op_q;
    out_alu_sel_d  = out_alu_sel_q;
    out_operand1_d = out_operand1_q;
    out_operand2_d = out_operand2_q;
    out_we_d       = out_we_q;
    out_wa_d       = out_wa_q;
    out_illegal_d  = out_illegal_q;
    if (flush) begin
      ir_valid_d  = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      if (advance) begin
        out_valid_d    = 1'b1;
        out_pc_d       = ir_pc_q;
        out_alu_op_d   = dec_alu_op;
        out_alu_sel_d  = dec_alu_sel;
        out_operand1_d = dec_operand1;
        out_operand2_d = dec_operand2;
        out_we_d       = dec_we;
        out_wa_d       = dec_wa;
        out_illegal_d  = dec_illegal;
      end else if (out_ready) begin
        out_valid_d = 1'b0;
      end
      // Refill and drain may happen on the same edge, giving one instruction per cycle.
      if (in_valid && in_ready) begin
        ir_valid_d = 1'b1;
        ir_pc_d    = in_pc;
        ir_instr_d = in_instruction;
      end else if (advance) begin
        ir_valid_d = 1'b0;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ir_valid_q     <= 1'b0;
      ir_pc_q        <= '0;
      ir_instr_q     <= '0;
      out_valid_q    <= 1'b0;
      out_pc_q       <= '0;
      out_alu_op_q   <= '0;
      out_alu_sel_q  <= '0;
      out_operand1_q <= '0;
      out_operand2_q <= '0;
      out_we_q       <= 1'b0;
      out_wa_q       <= '0;
      out_illegal_q  <= 1'b0;
    end else begin
      ir_valid_q     <= ir_valid_d;
      ir_pc_q        <= ir_pc_d;
      ir_instr_q     <= ir_instr_d;
      out_valid_q    <= out_valid_d;
      out_pc_q       <= out_pc_d;
      out_alu_op_q   <= out_alu_op_d;
      out_alu_sel_q  <= out_alu_sel_d;
      out_operand1_q <= out_operand1_d;
      out_operand2_q <= out_operand2_d;
      out_we_q       <= out_we_d;
      out_wa_q       <= out_wa_d;
      out_illegal_q  <= out_illegal_d;
    end
  end

  assign out_valid         = out_valid_q;
  assign out_pc            = out_pc_q;
  assign out_alu_op        = out_alu_op_q;
  assign out_alu_sel       = out_alu_sel_q;
  assign out_operand1      = out_operand1_q;
  assign out_operand2      = out_operand2_q;
  assign out_write_enable  = out_we_q;
  assign out_write_address = out_wa_q;
  assign out_illegal       = out_illegal_q;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage; sits between the fetch pipeline register and execute.
- Captures a fetched instruction and decodes it, then drives the register-file read ports (read_enable1/2, read_address1/2) and consumes read_data1/2.
- Registers the decoded operation and operands into an ID/EX output register.
- Uses a valid/ready handshake on both sides, plus a synchronous flush.

Parameters:
- DATA_WIDTH, 32, width of instruction, PC and operand data.
- REG_ADDR_WIDTH, 5, register-file address width (32 registers).

Ports:
- clock  in  1  stage clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all in-flight state.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_pc  in  DATA_WIDTH  PC of the instruction.
- in_instruction  in  DATA_WIDTH  instruction word.
- read_enable1, read_enable2  out  1  register-file read enables.
- read_address1, read_address2  out  REG_ADDR_WIDTH  register-file read addresses.
- read_data1, read_data2  in  DATA_WIDTH  register-file read data (combinational).
- out_valid  out  1  ID/EX register holds a decoded instruction.
- out_ready  in  1  execute accepts the decoded instruction.
- out_pc  out  DATA_WIDTH  PC carried to execute.
- out_alu_op  out  8  operation code.
- out_alu_sel  out  3  operation class.
- out_operand1, out_operand2  out  DATA_WIDTH  source operands.
- out_write_enable  out  1  destination register write enable.
- out_write_address  out  REG_ADDR_WIDTH  destination register.
- out_illegal  out  1  unsupported opcode was decoded.

Behaviour:
- Internal state: instruction register IR (ir_valid, ir_pc, ir_instr) and the ID/EX output register.
- Reset (asynchronous): ir_valid=0, out_valid=0; every out_* data field = 0, out_write_enable=0, out_illegal=0.
- advance = ir_valid && (!out_valid || out_ready).
- in_ready = !ir_valid || advance. in_ready is combinational and never depends on in_valid.
- IR loads on in_valid && in_ready. ir_valid then = in_valid && in_ready, or stays 1 if IR holds without advancing.
- ID/EX register loads the decode of IR when advance=1.
  - When !advance && out_ready, out_valid drops to 0.
  - When !advance && !out_ready, the register holds all fields.
- Latency: an instruction accepted at edge N appears at the outputs after edge N+1. Sustained throughput is 1 per cycle.
- Register-file reads are driven combinationally from IR. Read enables are 0 when ir_valid=0.
- Operands:
  - operand1 = read_data1 if read_enable1 else 0.
  - operand2 = read_data2 if read_enable2 else the immediate.
- Decode (opcode = instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], funct = [5:0]):
  - ORI 0x0D: re1=1 addr rs; re2=0; imm = zero-extended [15:0]; op OR; dest rt.
  - ANDI 0x0C: as ORI, op AND.
  - XORI 0x0E: as ORI, op XOR.
  - LUI 0x0F: re1=1 addr 0; imm = {[15:0],16'h0}; op OR; dest rt.
  - SPECIAL 0x00 with funct 0x24/0x25/0x26/0x27: re1 = rs, re2 = rt; ops AND/OR/XOR/NOR; dest rd.
  - Word 0x00000000: NOP; write_enable=0, no reads.
  - Any other encoding: NOP with out_illegal=1. It is still passed downstream.
- Op encodings: NOP 8'h00, AND 8'h24, OR 8'h25, XOR 8'h26, NOR 8'h27. sel: NOP 3'b000, LOGIC 3'b001.
- Destination register 0: write_enable is forced to 0.
- flush:
  - At the edge, ir_valid=0 and out_valid=0.
  - in_ready is forced to 0 that cycle; an instruction offered during flush is dropped.
  - flush overrides simultaneous in_valid/advance.
- Simultaneous fill and drain: when out_ready=1 and in_valid=1 with both registers full, IR and ID/EX both load on the same edge (no bubble).
- Reset mid-operation discards both entries immediately.

Decomposition:
- Shared package/defines:
  - opcode/funct constants;
  - ALU op and sel encodings;
  - ZeroWord, RegisterBus, RegisterAddressBus widths.
- Sub-module decode_logic: purely combinational; IR word plus read data in, decoded fields out. decode_stage holds the handshake and both registers.

Test Plan:
- Reset then ORI:
  - Stimulus: assert reset mid-run; then send 0x34011100 (ori $1,$0,0x1100) with out_ready=1.
  - During reset: all outputs 0, in_ready=1.
  - After the instruction: read_address1=0; two edges later out_valid=1, operand1=0, operand2=0x00001100, out_write_address=1, out_alu_op=8'h25.
- R-type OR:
  - Stimulus: 0x00221825 (or $3,$1,$2), read_data1=0x0F0F0000, read_data2=0x000000F0.
  - Response: read_address1=1, read_address2=2, operand1=0x0F0F0000, operand2=0x000000F0, dest=3, sel=3'b001.
- Backpressure:
  - Stimulus: 3 back-to-back instructions, out_ready=0 for 4 cycles.
  - Response: after 2 accepts in_ready=0; outputs hold the first instruction. On release, all three instructions emerge in order, one per cycle.
- Flush:
  - Stimulus: flush with IR and ID/EX both full, in_valid=1.
  - Response: next cycle out_valid=0, the offered instruction is dropped, in_ready=1 after the flush cycle.
- Illegal and NOP:
  - Stimulus: 0xFC000000, then 0x00000000.
  - Response: the first gives out_illegal=1, write_enable=0, op 8'h00. The second gives out_illegal=0, no read enables.
- LUI and register 0:
  - Stimulus: lui $0,0xABCD (0x3C00ABCD).
  - Response: operand2=0xABCD0000, out_write_enable=0.
